// File: rtl/vga_timing_core.sv
// Parametrised VGA sync generator: divides dclk to the pixel rate, publishes request coordinates
// to a pipelined renderer and re-aligns syncs/blanking with the returned colour.
module vga_timing_core #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int REN_LAT  = 2,
   parameter int RW       = 3,
   parameter int GW       = 3,
   parameter int BW       = 2,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HCW     = $clog2(H_TOTAL),
   localparam int VCW     = $clog2(V_TOTAL)
) (
   input  logic                  dclk,
   input  logic                  clr,
   output logic                  pix_tick,
   output logic [HCW-1:0]        hcount,
   output logic [VCW-1:0]        vcount,
   output logic                  de_req,
   output logic                  line_start,
   output logic                  frame_start,
   input  logic [RW+GW+BW-1:0]   rgb_in,
   output logic                  hsync,
   output logic                  vsync,
   output logic [RW-1:0]         red,
   output logic [GW-1:0]         green,
   output logic [BW-1:0]         blue
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div, div_nxt;
   logic          h_last, v_last;
   logic          hs_raw, vs_raw;
   logic [2:0]    tap_in, tail;

   // pix_tick is registered so that it is low while clr is held, even with CLK_DIV=1.
   always_comb div_nxt = (div == DW'(CLK_DIV - 1)) ? '0 : div + DW'(1);

   always_ff @(posedge dclk) begin
      if (clr) begin
         div      <= '0;
         pix_tick <= 1'b0;
      end else begin
         div      <= div_nxt;
         pix_tick <= (div_nxt == DW'(CLK_DIV - 1));
      end
   end

   assign h_last = (hcount == HCW'(H_TOTAL - 1));
   assign v_last = (vcount == VCW'(V_TOTAL - 1));

   always_ff @(posedge dclk) begin
      if (clr) begin
         hcount      <= '0;
         vcount      <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_tick && h_last;
         frame_start <= pix_tick && h_last && v_last;
         if (pix_tick) begin
            if (h_last) begin
               hcount <= '0;
               vcount <= v_last ? '0 : vcount + VCW'(1);
            end else begin
               hcount <= hcount + HCW'(1);
            end
         end
      end
   end

   assign de_req = (hcount < HCW'(H_ACTIVE)) && (vcount < VCW'(V_ACTIVE));
   assign hs_raw = ((hcount >= HCW'(H_ACTIVE + H_FP)) && (hcount < HCW'(H_ACTIVE + H_FP + H_SYNC)))
                   ? H_POL : ~H_POL;
   assign vs_raw = ((vcount >= VCW'(V_ACTIVE + V_FP)) && (vcount < VCW'(V_ACTIVE + V_FP + V_SYNC)))
                   ? V_POL : ~V_POL;
   assign tap_in = {hs_raw, vs_raw, de_req};

   // Timing shadow that walks alongside the renderer pipeline.
   generate
      if (REN_LAT == 0) begin : g_nodly
         assign tail = tap_in;
      end else begin : g_dly
         logic [2:0] stage [REN_LAT];
         always_ff @(posedge dclk) begin
            if (clr) begin
               for (int i = 0; i < REN_LAT; i++) stage[i] <= {~H_POL, ~V_POL, 1'b0};
            end else if (pix_tick) begin
               stage[0] <= tap_in;
               for (int i = 1; i < REN_LAT; i++) stage[i] <= stage[i-1];
            end
         end
         assign tail = stage[REN_LAT-1];
      end
   endgenerate

   always_ff @(posedge dclk) begin
      if (clr) begin
         hsync <= ~H_POL;
         vsync <= ~V_POL;
         {red, green, blue} <= '0;
      end else if (pix_tick) begin
         hsync <= tail[2];
         vsync <= tail[1];
         {red, green, blue} <= tail[0] ? rgb_in : '0;
      end
   end

endmodule
